// File: rtl/mips_pipe_pkg.sv
// Shared types and default widths for the two-entry MIPS pipeline register.
package mips_pipe_pkg;
  localparam int CTRL_W_DEF = 8;
  localparam int DATA_W_DEF = 111;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipeState_t;
endpackage

// File: rtl/mips_pipe_slot.sv
// One pipeline entry register: control + payload with load enable.
// clrCtrl zeroes only the control field so the payload keeps its last value.
module mips_pipe_slot
  import mips_pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load,
  input  logic              clrCtrl,
  input  logic [CTRL_W-1:0] ctrlD,
  input  logic [DATA_W-1:0] dataD,
  output logic [CTRL_W-1:0] ctrlQ,
  output logic [DATA_W-1:0] dataQ
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ctrlQ <= '0;
      dataQ <= '0;
    end else if (clrCtrl) begin
      ctrlQ <= '0;
    end else if (load) begin
      ctrlQ <= ctrlD;
      dataQ <= dataD;
    end
  end

endmodule

// File: rtl/mips_pipe_reg.sv
// Skid-buffered pipeline register between MIPS stages with a bubble counter.
// state | meaning
// EMPTY | no entry held; OUT_VALID=0, OUT_CTRL forced to NOP
// ONE   | main holds the head entry; can accept
// TWO   | main and skid both full; upstream stalled
module mips_pipe_reg
  import mips_pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FLUSH,
  input  logic              CNT_CLR,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [CTRL_W-1:0] IN_CTRL,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CNT_W-1:0]  BUBBLE_CNT
);

  pipeState_t        state, nextState;
  logic              accept, issue;
  logic              loadMain, loadSkid, clrMain, clrSkid, mainFromSkid;
  logic              outValidQ, inReadyQ;
  logic [CTRL_W-1:0] mainCtrlD, skidCtrl;
  logic [DATA_W-1:0] mainDataD, skidData;

  assign accept    = IN_VALID & inReadyQ;
  assign issue     = outValidQ & OUT_READY;
  assign IN_READY  = inReadyQ;
  assign OUT_VALID = outValidQ;

  always_comb begin
    nextState    = state;
    loadMain     = 1'b0;
    loadSkid     = 1'b0;
    clrMain      = 1'b0;
    clrSkid      = 1'b0;
    mainFromSkid = 1'b0;
    if (FLUSH) begin
      nextState = EMPTY;
      clrMain   = 1'b1;
      clrSkid   = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            nextState = ONE;
            loadMain  = 1'b1;
          end
        end
        ONE: begin
          if (accept && issue) begin
            loadMain = 1'b1;
          end else if (accept) begin
            nextState = TWO;
            loadSkid  = 1'b1;
          end else if (issue) begin
            nextState = EMPTY;
            clrMain   = 1'b1;
          end
        end
        TWO: begin
          if (issue) begin
            nextState    = ONE;
            loadMain     = 1'b1;
            mainFromSkid = 1'b1;
          end
        end
        default: begin
          nextState = EMPTY;
          clrMain   = 1'b1;
          clrSkid   = 1'b1;
        end
      endcase
    end
  end

  // Handshake outputs are flops fed from nextState, so OUT_READY never reaches IN_READY combinationally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= EMPTY;
      outValidQ <= 1'b0;
      inReadyQ  <= 1'b1;
    end else begin
      state     <= nextState;
      outValidQ <= (nextState != EMPTY);
      inReadyQ  <= (nextState != TWO);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BUBBLE_CNT <= '0;
    end else if (CNT_CLR) begin
      BUBBLE_CNT <= '0;
    end else if (!outValidQ && OUT_READY && (BUBBLE_CNT != '1)) begin
      BUBBLE_CNT <= BUBBLE_CNT + CNT_W'(1);
    end
  end

  assign mainCtrlD = mainFromSkid ? skidCtrl : IN_CTRL;
  assign mainDataD = mainFromSkid ? skidData : IN_DATA;

  mips_pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) uMain (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .load    (loadMain),
    .clrCtrl (clrMain),
    .ctrlD   (mainCtrlD),
    .dataD   (mainDataD),
    .ctrlQ   (OUT_CTRL),
    .dataQ   (OUT_DATA)
  );

  mips_pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) uSkid (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .load    (loadSkid),
    .clrCtrl (clrSkid),
    .ctrlD   (IN_CTRL),
    .dataD   (IN_DATA),
    .ctrlQ   (skidCtrl),
    .dataQ   (skidData)
  );

endmodule

// File: tb/tb_mips_pipe_reg.sv
// Bench for mips_pipe_reg: queue-based reference model compared every cycle,
// plus directed sequences with literal expectations and a random soak.
module tb_mips_pipe_reg;
  localparam int CW = 8;
  localparam int DW = 111;
  localparam int NW = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b1;
  logic          FLUSH = 1'b0;
  logic          CNT_CLR = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [CW-1:0] IN_CTRL = '0;
  logic [DW-1:0] IN_DATA = '0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic [CW-1:0] OUT_CTRL;
  logic [DW-1:0] OUT_DATA;
  logic [NW-1:0] BUBBLE_CNT;

  mips_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .FLUSH      (FLUSH),
    .CNT_CLR    (CNT_CLR),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_CTRL    (IN_CTRL),
    .IN_DATA    (IN_DATA),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_CTRL   (OUT_CTRL),
    .OUT_DATA   (OUT_DATA),
    .BUBBLE_CNT (BUBBLE_CNT)
  );

  always #5 CLK = ~CLK;

  int passCnt = 0;
  int totalCnt = 0;
  bit chkEn = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  // Reference model: a FIFO of at most two entries, head shown downstream.
  logic [CW+DW-1:0] mq[$];
  logic [DW-1:0]    mLastData = '0;
  logic [NW-1:0]    mBub = '0;
  bit               mAcc, mIss, mIdle;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mq.delete();
      mLastData = '0;
      mBub = '0;
    end else begin
      mAcc  = IN_VALID && (mq.size() < 2);
      mIss  = (mq.size() > 0) && OUT_READY;
      mIdle = (mq.size() == 0) && OUT_READY;
      if (CNT_CLR) mBub = '0;
      else if (mIdle && (mBub != '1)) mBub = mBub + 1'b1;
      if (FLUSH) begin
        mq.delete();
      end else begin
        if (mIss) void'(mq.pop_front());
        if (mAcc) mq.push_back({IN_CTRL, IN_DATA});
      end
      if (mq.size() > 0) mLastData = mq[0][DW-1:0];
    end
  end

  always @(negedge CLK) begin
    if (chkEn) begin
      chk("m_out_valid", OUT_VALID, mq.size() > 0);
      chk("m_in_ready", IN_READY, mq.size() < 2);
      chk("m_out_ctrl", OUT_CTRL, (mq.size() > 0) ? mq[0][CW+DW-1:DW] : '0);
      chk("m_out_data", OUT_DATA, mLastData);
      chk("m_bubble_cnt", BUBBLE_CNT, mBub);
    end
  end

  task automatic cyc(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                     input bit ordy, input bit fl, input bit clr);
    @(negedge CLK);
    #1;
    IN_VALID  = v;
    IN_CTRL   = c;
    IN_DATA   = d;
    OUT_READY = ordy;
    FLUSH     = fl;
    CNT_CLR   = clr;
    @(posedge CLK);
    #2;
  endtask

  logic [127:0] rnd;

  initial begin
    #2;
    RST_N = 1'b0;
    chkEn = 1'b1;
    #1;
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_in_ready", IN_READY, 1);
    chk("rst_out_ctrl", OUT_CTRL, 0);
    chk("rst_out_data", OUT_DATA, 0);
    chk("rst_bubble", BUBBLE_CNT, 0);
    @(negedge CLK);
    #1;
    RST_N = 1'b1;

    // First entry straight after reset
    cyc(1, 8'hA5, 1, 1, 0, 0);
    chk("first_valid", OUT_VALID, 1);
    chk("first_ctrl", OUT_CTRL, 8'hA5);
    chk("first_data", OUT_DATA, 1);

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      cyc(1, CW'(8'h10 + i), DW'(i), 1, 0, 0);
      chk("stream_data", OUT_DATA, i);
      chk("stream_ctrl", OUT_CTRL, 8'h10 + i);
      chk("stream_in_ready", IN_READY, 1);
    end
    cyc(0, '0, '0, 1, 0, 0);
    chk("drain_valid", OUT_VALID, 0);
    chk("drain_ctrl_nop", OUT_CTRL, 0);
    chk("drain_data_hold", OUT_DATA, 8);

    // Backpressure fills both slots, third entry held off
    cyc(1, 8'h21, 1, 0, 0, 0);
    cyc(1, 8'h22, 2, 0, 0, 0);
    chk("bp_in_ready_two", IN_READY, 0);
    cyc(1, 8'h23, 3, 0, 0, 0);
    chk("bp_hold_data", OUT_DATA, 1);
    chk("bp_hold_ctrl", OUT_CTRL, 8'h21);
    chk("bp_still_full", IN_READY, 0);
    cyc(1, 8'h23, 3, 1, 0, 0);
    chk("bp_issue2", OUT_DATA, 2);
    chk("bp_ready_again", IN_READY, 1);
    cyc(1, 8'h23, 3, 1, 0, 0);
    chk("bp_issue3", OUT_DATA, 3);
    chk("bp_issue3_ctrl", OUT_CTRL, 8'h23);
    cyc(0, '0, '0, 1, 0, 0);
    chk("bp_empty", OUT_VALID, 0);

    // Flush in TWO drops everything, including the entry offered alongside it
    cyc(1, 8'h31, 1, 0, 0, 0);
    cyc(1, 8'h32, 2, 0, 0, 0);
    cyc(1, 8'h99, 9, 0, 1, 0);
    chk("flush_valid", OUT_VALID, 0);
    chk("flush_ctrl", OUT_CTRL, 0);
    chk("flush_in_ready", IN_READY, 1);
    cyc(0, '0, '0, 1, 0, 0);
    chk("flush_no_9", OUT_VALID, 0);

    // Bubble counter saturation and clear
    cyc(0, '0, '0, 1, 0, 1);
    chk("bub_clr", BUBBLE_CNT, 0);
    for (int i = 1; i <= 20; i++) begin
      cyc(0, '0, '0, 1, 0, 0);
      if (i == 14) chk("bub_14", BUBBLE_CNT, 14);
    end
    chk("bub_sat", BUBBLE_CNT, 15);
    cyc(0, '0, '0, 1, 0, 1);
    chk("bub_clr_override", BUBBLE_CNT, 0);

    // Asynchronous reset mid-cycle while full
    cyc(0, '0, '0, 1, 0, 0);
    cyc(0, '0, '0, 1, 0, 0);
    cyc(1, 8'h41, 1, 0, 0, 0);
    cyc(1, 8'h42, 2, 0, 0, 0);
    #1;
    RST_N = 1'b0;
    #1;
    chk("arst_valid", OUT_VALID, 0);
    chk("arst_in_ready", IN_READY, 1);
    chk("arst_bubble", BUBBLE_CNT, 0);
    chk("arst_ctrl", OUT_CTRL, 0);
    chk("arst_data", OUT_DATA, 0);
    @(negedge CLK);
    #1;
    RST_N = 1'b1;

    // Random soak against the model
    for (int i = 0; i < 500; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      cyc($urandom_range(0, 99) < 60, CW'($urandom), rnd[DW-1:0],
          $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 3);
    end
    for (int i = 0; i < 4; i++) cyc(0, '0, '0, 1, 0, 0);

    @(negedge CLK);
    #1;
    chkEn = 1'b0;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
